// File: rtl/counter_stepper_if.sv
// Command and Counter handshake bundle for counter_stepper.
// The master side is the environment (control logic plus the Counter);
// the slave side is the stepper itself.
interface counter_stepper_if #(
  parameter int DEKATRON_NUM = 6,
  parameter int STEP_WIDTH   = 8
);
  logic                      Cmd_Valid;
  logic                      Cmd_Ready;
  logic [1:0]                Cmd_Op;
  logic [STEP_WIDTH-1:0]     Cmd_Count;
  logic [DEKATRON_NUM*3-1:0] Cmd_Data;
  logic                      Done;
  logic [STEP_WIDTH-1:0]     Steps_Left;
  logic                      Cnt_Request;
  logic                      Cnt_Dec;
  logic                      Cnt_Set;
  logic [DEKATRON_NUM*3-1:0] Cnt_In;
  logic                      Cnt_Ready;

  modport master (
    output Cmd_Valid, Cmd_Op, Cmd_Count, Cmd_Data, Cnt_Ready,
    input  Cmd_Ready, Done, Steps_Left, Cnt_Request, Cnt_Dec, Cnt_Set, Cnt_In
  );

  modport slave (
    input  Cmd_Valid, Cmd_Op, Cmd_Count, Cmd_Data, Cnt_Ready,
    output Cmd_Ready, Done, Steps_Left, Cnt_Request, Cnt_Dec, Cnt_Set, Cnt_In
  );
endinterface

// File: rtl/counter_stepper.sv
// Multi-step command sequencer for a dekatron Counter. Turns one
// step-up / step-down / load command into the right number of single
// Request/Ready handshakes, then pulses Done once the Counter settles.
module counter_stepper #(
  parameter int DEKATRON_NUM = 6,
  parameter int STEP_WIDTH   = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  counter_stepper_if.slave   bus
);
  localparam int VALUE_WIDTH = DEKATRON_NUM * 3;

  localparam logic [1:0] OP_UP   = 2'b00;
  localparam logic [1:0] OP_DOWN = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SETTLE
  } state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              op_reg, op_next;
  logic [STEP_WIDTH-1:0]   steps_left_reg, steps_left_next;
  logic [VALUE_WIDTH-1:0]  cnt_in_reg, cnt_in_next;
  logic                    done_reg, done_next;
  logic                    cmd_ready_reg, cmd_ready_next;
  logic                    cnt_request_reg, cnt_request_next;
  logic                    cnt_dec_reg, cnt_dec_next;
  logic                    cnt_set_reg, cnt_set_next;

  // State and registered-output update.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg       <= IDLE;
      op_reg          <= 2'b00;
      steps_left_reg  <= '0;
      cnt_in_reg      <= '0;
      done_reg        <= 1'b0;
      cmd_ready_reg   <= 1'b1;
      cnt_request_reg <= 1'b0;
      cnt_dec_reg     <= 1'b0;
      cnt_set_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      op_reg          <= op_next;
      steps_left_reg  <= steps_left_next;
      cnt_in_reg      <= cnt_in_next;
      done_reg        <= done_next;
      cmd_ready_reg   <= cmd_ready_next;
      cnt_request_reg <= cnt_request_next;
      cnt_dec_reg     <= cnt_dec_next;
      cnt_set_reg     <= cnt_set_next;
    end
  end

  // Next-state logic; outputs are derived from the next state so that
  // every port comes straight from a flop.
  always_comb begin
    state_next      = state_reg;
    op_next         = op_reg;
    steps_left_next = steps_left_reg;
    cnt_in_next     = cnt_in_reg;
    done_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.Cmd_Valid && cmd_ready_reg) begin
          op_next     = bus.Cmd_Op;
          cnt_in_next = bus.Cmd_Data;
          case (bus.Cmd_Op)
            OP_UP, OP_DOWN: begin
              if (bus.Cmd_Count != '0) begin
                steps_left_next = bus.Cmd_Count;
                state_next      = ISSUE;
              end else begin
                state_next = SETTLE;
              end
            end
            OP_LOAD: begin
              steps_left_next = STEP_WIDTH'(1);
              state_next      = ISSUE;
            end
            // Reserved op: completes like a zero-count step.
            default: state_next = SETTLE;
          endcase
        end
      end
      ISSUE: begin
        // Request is held high; the Counter drops Ready while busy, so
        // each Ready edge is exactly one accepted step.
        if (bus.Cnt_Ready) begin
          steps_left_next = steps_left_reg - STEP_WIDTH'(1);
          if (steps_left_reg == STEP_WIDTH'(1)) begin
            state_next = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (bus.Cnt_Ready) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    cmd_ready_next   = (state_next == IDLE);
    cnt_request_next = (state_next == ISSUE);
    cnt_dec_next     = cnt_request_next && (op_next == OP_DOWN);
    cnt_set_next     = cnt_request_next && (op_next == OP_LOAD);
  end

  assign bus.Cmd_Ready   = cmd_ready_reg;
  assign bus.Done        = done_reg;
  assign bus.Steps_Left  = steps_left_reg;
  assign bus.Cnt_Request = cnt_request_reg;
  assign bus.Cnt_Dec     = cnt_dec_reg;
  assign bus.Cnt_Set     = cnt_set_reg;
  assign bus.Cnt_In      = cnt_in_reg;
endmodule

// File: tb/tb_counter_stepper.sv
// Bench for counter_stepper: a behavioural Counter with programmable step
// delay, a command driver that predicts each command's outcome, and an
// independent monitor that checks handshakes and Done against the queue.
module tb_counter_stepper;
  localparam int DN = 6;
  localparam int SW = 8;
  localparam int VW = DN * 3;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  counter_stepper_if #(.DEKATRON_NUM(DN), .STEP_WIDTH(SW)) bus ();

  counter_stepper #(.DEKATRON_NUM(DN), .STEP_WIDTH(SW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]    op;
    int            n;
    logic [VW-1:0] final_val;
    logic [VW-1:0] data;
    int            done_cyc;
    bit            chk_lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_acc   = 0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;

  function automatic void check(string name, longint act, longint req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endfunction

  function automatic void fail_now(string name);
    total_cnt++;
    $display("FAIL %s: event did not occur as expected (cycle %0d)", name, cyc);
  endfunction

  always @(posedge Clk) cyc <= cyc + 1;

  // Behavioural Counter: accepts on Request&Ready, then stays busy for
  // d_val-1 cycles. Not reset by Rst, so an in-flight step completes.
  logic          cnt_ready = 1'b1;
  int            d_val     = 3;
  int            wait_cnt  = 0;
  logic [VW-1:0] cnt_value = '0;
  int            acc_total = 0;
  assign bus.Cnt_Ready = cnt_ready;

  always @(posedge Clk) begin
    if (bus.Cnt_Request && cnt_ready) begin
      acc_total <= acc_total + 1;
      if (bus.Cnt_Set)      cnt_value <= bus.Cnt_In;
      else if (bus.Cnt_Dec) cnt_value <= cnt_value - 1'b1;
      else                  cnt_value <= cnt_value + 1'b1;
      if (d_val > 1) begin
        cnt_ready <= 1'b0;
        wait_cnt  <= d_val - 1;
      end
    end else if (!cnt_ready) begin
      if (wait_cnt <= 1) begin
        cnt_ready <= 1'b1;
        wait_cnt  <= 0;
      end else begin
        wait_cnt <= wait_cnt - 1;
      end
    end
  end

  // Monitor: checks every accepted step and every Done pulse.
  initial begin
    forever begin
      @(negedge Clk);
      #1;
      if (Rst) begin
        exp_q.delete();
        mon_acc = 0;
      end else begin
        if (bus.Cnt_Request && bus.Cnt_Ready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_request");
          end else begin
            check("req_dec", bus.Cnt_Dec, exp_q[0].op == 2'b01);
            check("req_set", bus.Cnt_Set, exp_q[0].op == 2'b10);
            check("steps_left", bus.Steps_Left, exp_q[0].n - mon_acc);
            if (exp_q[0].op == 2'b10) check("cnt_in", bus.Cnt_In, exp_q[0].data);
            mon_acc++;
          end
        end
        if (bus.Done) begin
          if (exp_q.size() == 0) begin
            fail_now("spurious_done");
          end else begin
            mon_e = exp_q.pop_front();
            check("accept_count", mon_acc, mon_e.n);
            check("counter_value", cnt_value, mon_e.final_val);
            if (mon_e.chk_lat) check("done_cycle", cyc, mon_e.done_cyc);
            mon_acc = 0;
          end
        end
      end
    end
  end

  // Issue one command and queue its predicted outcome.
  task automatic send_cmd(input logic [1:0] op, input int cnt,
                          input logic [VW-1:0] data, input bit chk_lat);
    exp_t e;
    int   k;
    k = 0;
    @(negedge Clk);
    while (!bus.Cmd_Ready && k < 5000) begin
      @(negedge Clk);
      k++;
    end
    if (!bus.Cmd_Ready) begin
      fail_now("cmd_ready_timeout");
      return;
    end
    bus.Cmd_Valid = 1'b1;
    bus.Cmd_Op    = op;
    bus.Cmd_Count = SW'(cnt);
    bus.Cmd_Data  = data;
    e.op      = op;
    e.data    = data;
    e.chk_lat = chk_lat;
    case (op)
      2'b00: begin e.n = cnt; e.final_val = cnt_value + VW'(cnt); end
      2'b01: begin e.n = cnt; e.final_val = cnt_value - VW'(cnt); end
      2'b10: begin e.n = 1;   e.final_val = data;                 end
      default: begin e.n = 0; e.final_val = cnt_value;            end
    endcase
    e.done_cyc = cyc + 2 + e.n * d_val;
    exp_q.push_back(e);
    $display("cmd op=%0d count=%0d data=%h D=%0d start=%h cycle=%0d",
             op, cnt, data, d_val, cnt_value, cyc);
    @(negedge Clk);
    bus.Cmd_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 5000) begin
      @(negedge Clk);
      k++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] base;
    int            a0;
    int            k;
    logic [1:0]    rop;
    int            rn;

    bus.Cmd_Valid = 1'b0;
    bus.Cmd_Op    = 2'b00;
    bus.Cmd_Count = '0;
    bus.Cmd_Data  = '0;
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_cmd_ready", bus.Cmd_Ready, 1);
    check("rst_done", bus.Done, 0);
    check("rst_steps_left", bus.Steps_Left, 0);
    check("rst_request", bus.Cnt_Request, 0);
    check("rst_dec", bus.Cnt_Dec, 0);
    check("rst_set", bus.Cnt_Set, 0);
    check("rst_cnt_in", bus.Cnt_In, 0);
    Rst = 1'b0;

    // Directed cases from the test plan.
    d_val = 3;
    send_cmd(2'b00, 2, '0, 1'b1);
    wait_idle();
    send_cmd(2'b00, 3, '0, 1'b1);
    wait_idle();
    send_cmd(2'b01, 3, '0, 1'b1);
    wait_idle();
    check("steps_left_after_down", bus.Steps_Left, 0);
    send_cmd(2'b10, 7, 18'h2A5, 1'b1);
    wait_idle();
    send_cmd(2'b00, 0, '0, 1'b1);
    send_cmd(2'b11, 9, 18'h3, 1'b1);
    wait_idle();
    d_val = 1;
    send_cmd(2'b00, 255, '0, 1'b1);
    wait_idle();

    // A command raised while busy must be ignored.
    d_val = 2;
    send_cmd(2'b00, 4, '0, 1'b1);
    @(negedge Clk);
    check("cmd_ready_busy", bus.Cmd_Ready, 0);
    bus.Cmd_Valid = 1'b1;
    bus.Cmd_Op    = 2'b10;
    bus.Cmd_Data  = 18'h1234;
    @(negedge Clk);
    bus.Cmd_Valid = 1'b0;
    wait_idle();

    // Randomized commands.
    for (int i = 0; i < 20; i++) begin
      d_val = $urandom_range(1, 4);
      rop   = 2'($urandom_range(0, 3));
      rn    = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
      send_cmd(rop, rn, VW'($urandom), 1'b1);
      wait_idle();
    end

    // Reset after two accepted steps of a five-step move.
    d_val = 6;
    base  = cnt_value;
    a0    = acc_total;
    send_cmd(2'b00, 5, '0, 1'b1);
    k = 0;
    while (acc_total < a0 + 2 && k < 1000) begin
      @(negedge Clk);
      k++;
    end
    if (acc_total < a0 + 2) fail_now("two_accepts_timeout");
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("post_rst_request", bus.Cnt_Request, 0);
    check("post_rst_done", bus.Done, 0);
    check("post_rst_steps_left", bus.Steps_Left, 0);
    check("post_rst_cmd_ready", bus.Cmd_Ready, 1);
    send_cmd(2'b00, 1, '0, 1'b0);
    wait_idle();
    check("post_rst_counter", cnt_value, base + VW'(3));

    repeat (3) @(negedge Clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
